// File: rtl/button_debouncer_mc.sv
// rtl/button_debouncer_mc.sv - multi-channel button synchroniser, debouncer, edge and press-length detector
module button_debouncer_mc #(
  parameter int CLK_FREQ    = 100_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 300,
  parameter int N_CH        = 4,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic [N_CH-1:0] long_pulse,
  output logic [N_CH-1:0] long_held,
  output logic [N_CH-1:0] short_pulse
);

  localparam int DB_CYCLES   = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int LONG_CYCLES = CLK_FREQ / 1000 * LONG_MS;
  localparam int DB_W        = $clog2(DB_CYCLES + 1);
  localparam int HOLD_W      = $clog2(LONG_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    LONG  = 2'd2
  } hold_state_t;

  logic [N_CH-1:0] pin_level;

  assign pin_level = btn_in ^ {N_CH{ACTIVE_LOW}};

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic              s1;
    logic              s2;
    logic              stable;
    logic              stable_nxt;
    logic [DB_W-1:0]   db_cnt;
    logic [DB_W-1:0]   db_cnt_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_nxt;
    hold_state_t       state;
    hold_state_t       state_nxt;
    logic              rise_ev;
    logic              fall_ev;
    logic              long_ev;
    logic              short_ev;
    logic              rise_q;
    logic              fall_q;
    logic              long_q;
    logic              short_q;

    // Any sample that agrees with the stable level restarts the window.
    always_comb begin
      stable_nxt = stable;
      db_cnt_nxt = db_cnt + DB_W'(1);
      if (s2 == stable) begin
        db_cnt_nxt = '0;
      end else if (db_cnt == DB_LAST) begin
        stable_nxt = s2;
        db_cnt_nxt = '0;
      end
    end

    assign rise_ev = stable_nxt & ~stable;
    assign fall_ev = ~stable_nxt & stable;

    // A release on the edge that would fire long_pulse is reported as short.
    always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = hold_cnt;
      long_ev      = 1'b0;
      short_ev     = 1'b0;
      case (state)
        IDLE: begin
          hold_cnt_nxt = '0;
          if (rise_ev) begin
            state_nxt = COUNT;
          end
        end
        COUNT: begin
          if (fall_ev) begin
            short_ev     = 1'b1;
            state_nxt    = IDLE;
            hold_cnt_nxt = '0;
          end else if (hold_cnt == LONG_LAST) begin
            long_ev   = 1'b1;
            state_nxt = LONG;
          end else begin
            hold_cnt_nxt = hold_cnt + HOLD_W'(1);
          end
        end
        LONG: begin
          if (fall_ev) begin
            state_nxt    = IDLE;
            hold_cnt_nxt = '0;
          end
        end
        default: begin
          state_nxt    = IDLE;
          hold_cnt_nxt = '0;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s1       <= 1'b0;
        s2       <= 1'b0;
        stable   <= 1'b0;
        db_cnt   <= '0;
        hold_cnt <= '0;
        state    <= IDLE;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
        long_q   <= 1'b0;
        short_q  <= 1'b0;
      end else begin
        s1       <= pin_level[ch];
        s2       <= s1;
        stable   <= stable_nxt;
        db_cnt   <= db_cnt_nxt;
        hold_cnt <= hold_cnt_nxt;
        state    <= state_nxt;
        rise_q   <= rise_ev;
        fall_q   <= fall_ev;
        long_q   <= long_ev;
        short_q  <= short_ev;
      end
    end

    assign btn_out[ch]     = stable;
    assign rise_pulse[ch]  = rise_q;
    assign fall_pulse[ch]  = fall_q;
    assign long_pulse[ch]  = long_q;
    assign short_pulse[ch] = short_q;
    assign long_held[ch]   = (state == LONG);
  end

endmodule

// File: tb/tb_button_debouncer_mc.sv
// tb/tb_button_debouncer_mc.sv - scoreboard bench for button_debouncer_mc (scaled clock, active-low pins)
module tb_button_debouncer_mc;

  localparam int N  = 4;
  localparam int DB = 200;
  localparam int LG = 3000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn_in = '1;
  logic [N-1:0] btn_out;
  logic [N-1:0] rise_pulse;
  logic [N-1:0] fall_pulse;
  logic [N-1:0] long_pulse;
  logic [N-1:0] long_held;
  logic [N-1:0] short_pulse;

  button_debouncer_mc #(
    .CLK_FREQ   (10_000),
    .DEBOUNCE_MS(20),
    .LONG_MS    (300),
    .N_CH       (N),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .btn_out    (btn_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .long_pulse (long_pulse),
    .long_held  (long_held),
    .short_pulse(short_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           cyc;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] lng;
    logic [N-1:0] shrt;
    logic [N-1:0] btn;
    logic [N-1:0] held;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  task automatic expect_ev(input int c, input logic [N-1:0] r, input logic [N-1:0] f,
                           input logic [N-1:0] l, input logic [N-1:0] s,
                           input logic [N-1:0] b, input logic [N-1:0] h);
    ev_t e;
    e.cyc  = c;
    e.rise = r;
    e.fall = f;
    e.lng  = l;
    e.shrt = s;
    e.btn  = b;
    e.held = h;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b at cyc=%0d", name, got, want, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_pin(input int ch, input bit pressed);
    btn_in[ch] = ~pressed;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_btn_out"}, btn_out, '0);
    check({tag, "_rise"}, rise_pulse, '0);
    check({tag, "_fall"}, fall_pulse, '0);
    check({tag, "_long"}, long_pulse, '0);
    check({tag, "_short"}, short_pulse, '0);
    check({tag, "_held"}, long_held, '0);
  endtask

  // Every pulse the DUT shows must match the oldest pending expectation.
  ev_t got_e;
  always @(negedge clk) begin
    if (|{rise_pulse, fall_pulse, long_pulse, short_pulse}) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event cyc=%0d rise=%b fall=%b long=%b short=%b",
                 cyc, rise_pulse, fall_pulse, long_pulse, short_pulse);
      end else begin
        got_e = exp_q.pop_front();
        if (got_e.cyc != cyc || got_e.rise !== rise_pulse || got_e.fall !== fall_pulse ||
            got_e.lng !== long_pulse || got_e.shrt !== short_pulse ||
            got_e.btn !== btn_out || got_e.held !== long_held) begin
          bad++;
          $display("FAIL event got cyc=%0d rise=%b fall=%b long=%b short=%b btn=%b held=%b want cyc=%0d rise=%b fall=%b long=%b short=%b btn=%b held=%b",
                   cyc, rise_pulse, fall_pulse, long_pulse, short_pulse, btn_out, long_held,
                   got_e.cyc, got_e.rise, got_e.fall, got_e.lng, got_e.shrt, got_e.btn, got_e.held);
        end
      end
    end
  end

  initial begin
    int d;
    int r;

    rst    = 1'b1;
    btn_in = '1;
    tick(3);
    check_all_zero("reset");
    rst = 1'b0;
    tick(5);

    // glitch on ch0 shorter than the window
    set_pin(0, 1'b1);
    tick(50);
    set_pin(0, 1'b0);
    tick(300);
    check("glitch_btn_out", btn_out, '0);

    // chatter on ch1, then a steady press
    for (int k = 0; k < 10; k++) begin
      set_pin(1, (k % 2) == 0);
      tick(10);
    end
    d = cyc;
    set_pin(1, 1'b1);
    expect_ev(d + DB + 2, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    tick(300);
    check("chatter_btn_out", btn_out, 4'b0010);
    r = cyc;
    set_pin(1, 1'b0);
    expect_ev(r + DB + 2, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
    tick(250);

    // short press ch0
    d = cyc;
    set_pin(0, 1'b1);
    expect_ev(d + DB + 2, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    tick(1000);
    r = cyc;
    set_pin(0, 1'b0);
    expect_ev(r + DB + 2, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    tick(250);

    // long press ch2
    d = cyc;
    set_pin(2, 1'b1);
    expect_ev(d + DB + 2, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
    expect_ev(d + DB + 2 + LG, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0100);
    tick(4000);
    check("long_held_level", long_held, 4'b0100);
    r = cyc;
    set_pin(2, 1'b0);
    expect_ev(r + DB + 2, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick(250);

    // release debounces on the very edge long_pulse would fire: short wins
    d = cyc;
    set_pin(2, 1'b1);
    expect_ev(d + DB + 2, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
    tick(LG);
    set_pin(2, 1'b0);
    expect_ev(d + DB + 2 + LG, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
    tick(250);

    // release one cycle later: long fires, then a non-short release
    d = cyc;
    set_pin(2, 1'b1);
    expect_ev(d + DB + 2, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
    expect_ev(d + DB + 2 + LG, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0100, 4'b0100);
    tick(LG + 1);
    set_pin(2, 1'b0);
    expect_ev(d + DB + 3 + LG, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick(250);

    // ch0 and ch3 together while ch1 chatters
    d = cyc;
    set_pin(0, 1'b1);
    set_pin(3, 1'b1);
    expect_ev(d + DB + 2, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b1001, 4'b0000);
    expect_ev(d + 100 + DB + 2, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b1011, 4'b0000);
    for (int k = 0; k < 10; k++) begin
      set_pin(1, (k % 2) == 0);
      tick(10);
    end
    set_pin(1, 1'b1);
    tick(500);
    r = cyc;
    set_pin(0, 1'b0);
    set_pin(1, 1'b0);
    set_pin(3, 1'b0);
    expect_ev(r + DB + 2, 4'b0000, 4'b1011, 4'b0000, 4'b1011, 4'b0000, 4'b0000);
    tick(250);

    // reset in the middle of a press
    d = cyc;
    set_pin(0, 1'b1);
    expect_ev(d + DB + 2, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    tick(1500);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_all_zero("midreset");
    expect_ev(cyc + DB + 2, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    tick(800);
    r = cyc;
    set_pin(0, 1'b0);
    expect_ev(r + DB + 2, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    tick(250);

    tick(20);
    while (exp_q.size() > 0) begin
      got_e = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL missing_event want cyc=%0d rise=%b fall=%b long=%b short=%b",
               got_e.cyc, got_e.rise, got_e.fall, got_e.lng, got_e.shrt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_debouncer_mc.md
# button_debouncer_mc

Multi-channel button front end for the Morse keyer: it synchronises, debounces and edge-detects N_CH raw push-button inputs, and classifies each press as short or long. It supersedes the single-channel debouncer, adding channel count, input polarity selection, edge pulses and press-duration detection. It sits between the board pins and the Morse symbol decoder and menu logic, so a dot/dash decision needs no extra timer downstream.

## Interface
- CLK_FREQ, 100_000: clk frequency in Hz.
- DEBOUNCE_MS, 20: stability window in ms. DB_CYCLES = CLK_FREQ/1000*DEBOUNCE_MS, must be ≥1.
- LONG_MS, 300: long-press threshold in ms. LONG_CYCLES = CLK_FREQ/1000*LONG_MS, must be ≥1.
- N_CH, 4: number of independent button channels, ≥1.
- ACTIVE_LOW, 0: 1 inverts btn_in, so a pressed pin reads 0.
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- btn_in  in  N_CH  raw asynchronous button pins.
- btn_out  out  N_CH  debounced pressed level (1 = pressed).
- rise_pulse  out  N_CH  1-cycle pulse on a debounced press.
- fall_pulse  out  N_CH  1-cycle pulse on a debounced release.
- long_pulse  out  N_CH  1-cycle pulse when a press reaches LONG_CYCLES.
- long_held  out  N_CH  level, 1 from long_pulse until release.
- short_pulse  out  N_CH  1-cycle pulse on a release that occurs before long_pulse.

## Operation
- Channels are fully independent. Each channel is one replicated slice with no shared state.
- Per channel: polarity XOR, then a 2-FF synchroniser (s1, s2), then the debounce counter db_cnt (width $clog2(DB_CYCLES+1)), the stable register, the hold counter hold_cnt (width $clog2(LONG_CYCLES+1)) and long_held.
- Debounce, at every edge:
  - s2 == stable: db_cnt ← 0.
  - s2 ≠ stable and db_cnt == DB_CYCLES-1: stable ← s2, db_cnt ← 0.
  - Otherwise: db_cnt ← db_cnt+1.
  - Any sample equal to stable restarts the window.
- btn_out = stable, registered.
- rise_pulse and fall_pulse are registered and assert in the same cycle that btn_out first shows the new value.
- Hold state machine, per channel:
  - IDLE (btn_out=0): hold_cnt=0.
  - COUNT (btn_out=1, long_held=0): hold_cnt increments each edge. At hold_cnt == LONG_CYCLES-1 → long_pulse=1, long_held ← 1, go to LONG.
  - LONG: hold_cnt frozen, no further long_pulse.
  - On debounced release from COUNT: fall_pulse=1 and short_pulse=1, return to IDLE.
  - On debounced release from LONG: fall_pulse=1, short_pulse=0, long_held ← 0, return to IDLE.
- Simultaneous events across channels are reported in the same cycle with no arbitration.

## Timing
- Reset (rst=1 at an edge):
  - s1, s2, stable, db_cnt, hold_cnt and long_held are cleared.
  - All outputs are 0 in the following cycle.
  - No fall_pulse or short_pulse is generated by reset.
- Input latency: let edge 0 be the first edge sampling the new pin level. btn_out and the rise/fall pulse change after edge DB_CYCLES+1, i.e. DB_CYCLES+2 edges in total.
- Glitch rejection: any excursion shorter than DB_CYCLES consecutive s2 samples has no effect on any output.
- long_pulse asserts LONG_CYCLES cycles after the cycle in which rise_pulse asserted.
- If a release debounces on the same edge that would fire long_pulse, the release wins: fall_pulse and short_pulse assert, long_pulse does not.
- Reset mid-press: outputs clear. If the pin is still pressed, the channel re-debounces and emits rise_pulse DB_CYCLES+2 edges after rst deasserts.
- Pulses are never wider than 1 cycle. A new rise cannot occur earlier than DB_CYCLES cycles after a fall.

## Test plan
All scenarios use defaults: 100 cycles per ms, DB_CYCLES=2000, LONG_CYCLES=30000.
- Glitch: ch0 high for 5 ms (500 cycles), then low for 30 ms → btn_out, rise_pulse, fall_pulse and short_pulse stay 0 throughout.
- Chatter: ch1 toggles every 1 ms for 10 ms, then holds 1 for 30 ms → exactly one rise_pulse, 2002 edges after the last toggle's first sampling edge; btn_out=1 afterwards.
- Short press: ch0 high for 100 ms, then low → one rise_pulse; later one fall_pulse coincident with one short_pulse; long_pulse=0 and long_held=0 throughout.
- Long press: ch2 high for 400 ms, then low → long_pulse exactly 30000 cycles after rise_pulse; long_held=1 until release; release gives fall_pulse, short_pulse=0, and long_held=0 in the same cycle.
- Concurrency and polarity: ACTIVE_LOW=1. ch0 and ch3 pins driven low on the same cycle while ch1 chatters → ch0 and ch3 rise_pulse in the same cycle; ch1 produces no output until it is stable for 20 ms.
- Reset mid-press: ch0 held; pulse rst for 1 cycle 150 ms into the press → all outputs 0 next cycle with no fall_pulse; rise_pulse re-asserts 2002 edges after rst deasserts.
